mips_pipeline_cpu: RTL and testbench

Five-stage in-order MIPS-subset processor core (IF, ID, EX, MEM, WB) with on-chip instruction and data memories. It is the top of the CPU subsystem and is self-contained: only clock and reset enter. It has no hazard detection, no forwarding and no flush, so software schedules NOPs. Memories and the register file are loaded and inspected hierarchically by the bench.

---
 rtl/mips_pipeline_cpu.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mips_pipeline_cpu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_cpu.sv
// Five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB) with on-chip
// instruction and data memories. There are no interlocks, no forwarding and
// no squashing: software spaces dependent instructions and fills the three
// slots that follow every beq/j.

// Fetch stage: program counter and the 128-word instruction memory.
module mips_if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);
  logic [31:0] instruction [0:127];
  logic [31:0] PC;

  // PC moves one word per cycle unless a branch/jump resolved in MEM redirects it.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state is updated with <= so every register samples pre-edge values.
    if (!rst)          PC <= '0;
    else if (redirect) PC <= target;
    else               PC <= PC + 32'd4;
  end

  // Word-indexed fetch; addresses past 128 words alias.
  assign fetch_pc    = PC;
  assign fetch_instr = instruction[PC[8:2]];
endmodule

// Decode stage: 32x32 register file with combinational, write-through reads.
module mips_id_stage (
  input  logic        clk,
  input  logic [4:0]  rs_idx,
  input  logic [4:0]  rt_idx,
  input  logic        wb_we,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val
);
  logic [31:0] REG [0:31];

  // Write-back port; register 0 is hard-wired to zero.
  always_ff @(posedge clk) begin
    // NOTE: the register file has no reset -- contents are preloaded and must survive reset.
    if (wb_we && (wb_dst != 5'd0)) REG[wb_dst] <= wb_data;
  end

  // Read ports see a same-cycle write-back, so a producer 3 slots ahead is visible.
  always_comb begin
    // NOTE: both outputs get a value on every path, so no latch is inferred.
    rs_val = REG[rs_idx];
    rt_val = REG[rt_idx];
    if (rs_idx == 5'd0)                        rs_val = '0;
    else if (wb_we && (wb_dst == rs_idx))      rs_val = wb_data;
    if (rt_idx == 5'd0)                        rt_val = '0;
    else if (wb_we && (wb_dst == rt_idx))      rt_val = wb_data;
  end
endmodule

// Memory stage: 128-word data memory indexed directly by the address value.
module mips_mem_stage (
  input  logic        clk,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] DM [0:127];

  // Store port; the bubble state never asserts we, so reset blocks stray writes.
  always_ff @(posedge clk) begin
    if (we) DM[addr] <= wdata;
  end

  assign rdata = DM[addr];
endmodule

// Top level: stage instances plus the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
module mips_pipeline_cpu (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
                                    alu_src: 1'b0, branch: 1'b0, jump: 1'b0,
                                    alu_op: ALU_ADD};

  // Fetch
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  // IF/ID
  logic [31:0] fd_ir;
  logic [31:0] FD_PC;

  // Decode
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  ctrl_t       id_ctrl;
  logic [4:0]  id_dst;

  // ID/EX
  ctrl_t       de_ctrl;
  logic [31:0] de_pc4;
  logic [31:0] de_rs_val;
  logic [31:0] de_rt_val;
  logic [31:0] de_imm;
  logic [25:0] de_jidx;
  logic [4:0]  de_dst;

  // Execute
  logic [31:0] ex_b;
  logic [31:0] ex_alu;
  logic        ex_take;
  logic [31:0] ex_target;

  // EX/MEM
  logic        xm_reg_write;
  logic        xm_mem_to_reg;
  logic        xm_mem_write;
  logic [31:0] xm_alu;
  logic [31:0] xm_rt_val;
  logic [4:0]  xm_dst;
  logic        xm_take;
  logic [31:0] xm_target;

  // Memory
  logic [31:0] mem_rdata;

  // MEM/WB
  logic        mw_reg_write;
  logic [4:0]  mw_dst;
  logic [31:0] mw_data;

  mips_if_stage IF (
    .clk         (clk),
    .rst         (rst),
    .redirect    (xm_take),
    .target      (xm_target),
    .fetch_pc    (if_pc),
    .fetch_instr (if_instr)
  );

  // IF/ID register: reset loads a NOP so decode sees a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_ir <= NOP_INSTR;
      FD_PC <= '0;
    end else begin
      fd_ir <= if_instr;
      FD_PC <= if_pc + 32'd4;
    end
  end

  assign id_op    = fd_ir[31:26];
  assign id_rs    = fd_ir[25:21];
  assign id_rt    = fd_ir[20:16];
  assign id_rd    = fd_ir[15:11];
  assign id_funct = fd_ir[5:0];
  assign id_imm   = {{16{fd_ir[15]}}, fd_ir[15:0]};

  mips_id_stage ID (
    .clk     (clk),
    .rs_idx  (id_rs),
    .rt_idx  (id_rt),
    .wb_we   (mw_reg_write),
    .wb_dst  (mw_dst),
    .wb_data (mw_data),
    .rs_val  (id_rs_val),
    .rt_val  (id_rt_val)
  );

  // Main decoder: unsupported opcodes and functs fall through as bubbles.
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    id_dst  = id_rd;
    case (id_op)
      OP_RTYPE: begin
        case (id_funct)
          FN_ADD: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
          FN_SUB: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SUB; end
          FN_SLT: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_dst             = id_rt;
      end
      OP_SW: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ:  id_ctrl.branch = 1'b1;
      OP_J:    id_ctrl.jump   = 1'b1;
      default: ;
    endcase
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_ctrl   <= CTRL_BUBBLE;
      de_pc4    <= '0;
      de_rs_val <= '0;
      de_rt_val <= '0;
      de_imm    <= '0;
      de_jidx   <= '0;
      de_dst    <= '0;
    end else begin
      de_ctrl   <= id_ctrl;
      de_pc4    <= FD_PC;
      de_rs_val <= id_rs_val;
      de_rt_val <= id_rt_val;
      de_imm    <= id_imm;
      de_jidx   <= fd_ir[25:0];
      de_dst    <= id_dst;
    end
  end

  // ALU: add/sub wrap in 32 bits, slt compares signed.
  always_comb begin
    ex_b = de_ctrl.alu_src ? de_imm : de_rt_val;
    case (de_ctrl.alu_op)
      ALU_SUB: ex_alu = de_rs_val - ex_b;
      ALU_SLT: ex_alu = {31'd0, $signed(de_rs_val) < $signed(ex_b)};
      default: ex_alu = de_rs_val + ex_b;
    endcase
  end

  // Branch/jump resolution; the redirect is carried to MEM before it reaches the PC.
  assign ex_take   = de_ctrl.jump | (de_ctrl.branch & (de_rs_val == de_rt_val));
  assign ex_target = de_ctrl.jump ? {de_pc4[31:28], de_jidx, 2'b00}
                                  : de_pc4 + {de_imm[29:0], 2'b00};

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xm_reg_write  <= 1'b0;
      xm_mem_to_reg <= 1'b0;
      xm_mem_write  <= 1'b0;
      xm_alu        <= '0;
      xm_rt_val     <= '0;
      xm_dst        <= '0;
      xm_take       <= 1'b0;
      xm_target     <= '0;
    end else begin
      xm_reg_write  <= de_ctrl.reg_write;
      xm_mem_to_reg <= de_ctrl.mem_to_reg;
      xm_mem_write  <= de_ctrl.mem_write;
      xm_alu        <= ex_alu;
      xm_rt_val     <= de_rt_val;
      xm_dst        <= de_dst;
      xm_take       <= ex_take;
      xm_target     <= ex_target;
    end
  end

  mips_mem_stage MEM (
    .clk   (clk),
    .we    (xm_mem_write),
    .addr  (xm_alu[6:0]),
    .wdata (xm_rt_val),
    .rdata (mem_rdata)
  );

  // MEM/WB register: selects load data or ALU result for write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw_reg_write <= 1'b0;
      mw_dst       <= '0;
      mw_data      <= '0;
    end else begin
      mw_reg_write <= xm_reg_write;
      mw_dst       <= xm_dst;
      mw_data      <= xm_mem_to_reg ? mem_rdata : xm_alu;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Self-checking bench for mips_pipeline_cpu: ALU vector table, randomized
// programs against an instruction-level interpreter, and hand-written
// sequences for load/store, branches, jumps and reset.
module tb_mips_pipeline_cpu;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic [31:0] prog [0:127];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_dm [0:127];

  mips_pipeline_cpu dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_ins(input int idx);
    return {6'h02, 26'(idx)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Hold reset and clear all memories and the program buffer.
  task begin_test();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      prog[i] = NOP;
      dut.MEM.DM[i] <= '0;
    end
    for (int i = 0; i < 32; i++) dut.ID.REG[i] <= '0;
  endtask

  task load_imem();
    for (int i = 0; i < 128; i++) dut.IF.instruction[i] <= prog[i];
  endtask

  // Load the program, release reset, run a number of rising edges, stop at a falling edge.
  task go(input int edges);
    load_imem();
    @(negedge clk);
    rst = 1'b1;
    repeat (edges) @(posedge clk);
    @(negedge clk);
  endtask

  // Instruction-level interpreter: one architectural instruction at a time.
  task model_exec(input logic [31:0] w);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    int          rs, rt, rd, addr;
    op  = w[31:26];
    fn  = w[5:0];
    rs  = int'(w[25:21]);
    rt  = int'(w[20:16]);
    rd  = int'(w[15:11]);
    imm = {{16{w[15]}}, w[15:0]};
    a   = m_reg[rs];
    b   = m_reg[rt];
    addr = int'((a + imm) & 32'h7F);
    if (op == 6'h00) begin
      if (rd != 0) begin
        if (fn == 6'h20)      m_reg[rd] = a + b;
        else if (fn == 6'h22) m_reg[rd] = a - b;
        else if (fn == 6'h2A) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
    end else if (op == 6'h23) begin
      if (rt != 0) m_reg[rt] = m_dm[addr];
    end else if (op == 6'h2B) begin
      m_dm[addr] = b;
    end
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  alu_vec_t vecs [0:10];

  initial begin
    logic [31:0] v;
    logic [31:0] w;
    logic        found;
    int          kind, rs, rt, rd;

    vecs[0]  = '{6'h20, 32'd72,        32'd120,       32'd192,        "add basic"};
    vecs[1]  = '{6'h22, 32'd120,       32'd72,        32'd48,         "sub basic"};
    vecs[2]  = '{6'h2A, 32'd72,        32'd120,       32'd1,          "slt true"};
    vecs[3]  = '{6'h2A, 32'd120,       32'd72,        32'd0,          "slt false"};
    vecs[4]  = '{6'h2A, 32'hFFFF_FFFB, 32'd3,         32'd1,          "slt neg<pos"};
    vecs[5]  = '{6'h2A, 32'd3,         32'hFFFF_FFFB, 32'd0,          "slt pos<neg"};
    vecs[6]  = '{6'h2A, 32'd7,         32'd7,         32'd0,          "slt equal"};
    vecs[7]  = '{6'h22, 32'd0,         32'd1,         32'hFFFF_FFFF,  "sub wrap"};
    vecs[8]  = '{6'h20, 32'hFFFF_FFFF, 32'd2,         32'd1,          "add wrap"};
    vecs[9]  = '{6'h20, 32'h8000_0000, 32'h8000_0000, 32'd0,          "add overflow"};
    vecs[10] = '{6'h24, 32'd5,         32'd6,         SENT,           "bad funct"};

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset PC", dut.IF.PC, 32'd0);
    check("reset FD_PC", dut.FD_PC, 32'd0);

    // ALU vector table
    for (int t = 0; t < 11; t++) begin
      begin_test();
      dut.ID.REG[1] <= vecs[t].a;
      dut.ID.REG[2] <= vecs[t].b;
      dut.ID.REG[3] <= SENT;
      prog[0] = r_ins(vecs[t].fn, 1, 2, 3);
      go(8);
      check(vecs[t].name, dut.ID.REG[3], vecs[t].exp);
    end

    // Back-to-back independent ALU ops
    begin_test();
    dut.ID.REG[3] <= 32'd72;
    dut.ID.REG[4] <= 32'd120;
    dut.ID.REG[7] <= SENT;
    prog[0] = r_ins(6'h20, 3, 4, 5);
    prog[1] = r_ins(6'h22, 4, 3, 6);
    prog[2] = r_ins(6'h2A, 3, 4, 2);
    prog[3] = r_ins(6'h2A, 4, 3, 7);
    go(10);
    check("alu seq REG5", dut.ID.REG[5], 32'd192);
    check("alu seq REG6", dut.ID.REG[6], 32'd48);
    check("alu seq REG2", dut.ID.REG[2], 32'd1);
    check("alu seq REG7", dut.ID.REG[7], 32'd0);

    // Load/store
    begin_test();
    dut.MEM.DM[0] <= 32'd33;
    dut.MEM.DM[3] <= 32'd1;
    prog[0] = i_ins(6'h23, 0, 3, 16'd0);
    prog[1] = i_ins(6'h23, 0, 1, 16'd3);
    prog[5] = i_ins(6'h2B, 0, 3, 16'd4);
    go(15);
    check("lw REG3", dut.ID.REG[3], 32'd33);
    check("lw REG1", dut.ID.REG[1], 32'd1);
    check("sw DM4", dut.MEM.DM[4], 32'd33);

    // Wrap and $0
    begin_test();
    dut.ID.REG[8] <= 32'd1;
    dut.ID.REG[9] <= SENT;
    prog[0] = r_ins(6'h22, 0, 8, 9);
    prog[1] = r_ins(6'h20, 8, 8, 0);
    go(10);
    check("wrap REG9", dut.ID.REG[9], 32'hFFFF_FFFF);
    check("zero REG0", dut.ID.REG[0], 32'd0);

    // beq taken: slots 9..11 run, 12 skipped, 13 is the target
    begin_test();
    dut.ID.REG[1] <= 32'd5;
    for (int r = 10; r <= 14; r++) dut.ID.REG[r] <= SENT;
    prog[8] = i_ins(6'h04, 0, 0, 16'd4);
    for (int k = 0; k < 5; k++) prog[9 + k] = r_ins(6'h20, 1, 1, 10 + k);
    go(30);
    check("beq slot REG10", dut.ID.REG[10], 32'd10);
    check("beq slot REG11", dut.ID.REG[11], 32'd10);
    check("beq slot REG12", dut.ID.REG[12], 32'd10);
    check("beq skipped REG13", dut.ID.REG[13], SENT);
    check("beq target REG14", dut.ID.REG[14], 32'd10);

    // beq not taken: falls straight through
    begin_test();
    dut.ID.REG[1] <= 32'd5;
    dut.ID.REG[2] <= 32'd6;
    for (int r = 10; r <= 14; r++) dut.ID.REG[r] <= SENT;
    prog[8] = i_ins(6'h04, 1, 2, 16'd4);
    for (int k = 0; k < 5; k++) prog[9 + k] = r_ins(6'h20, 1, 1, 10 + k);
    go(30);
    for (int r = 10; r <= 14; r++) check($sformatf("beq nt REG%0d", r), dut.ID.REG[r], 32'd10);

    // Jump at 45 to 16, with cycle-accurate PC/FD_PC checks
    begin_test();
    dut.ID.REG[1] <= 32'd5;
    for (int r = 20; r <= 23; r++) dut.ID.REG[r] <= SENT;
    prog[45] = j_ins(16);
    for (int k = 0; k < 4; k++) prog[46 + k] = r_ins(6'h20, 1, 1, 20 + k);
    load_imem();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("first fetch FD_PC", dut.FD_PC, 32'd4);
    check("first fetch PC", dut.IF.PC, 32'd4);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (dut.FD_PC == 32'd196) found = 1'b1;
    end
    check("jump last slot reached", {31'd0, found}, 32'd1);
    check("jump PC at target", dut.IF.PC, 32'd64);
    @(negedge clk);
    check("jump FD_PC after target", dut.FD_PC, 32'd68);
    repeat (10) @(negedge clk);
    check("jump slot REG20", dut.ID.REG[20], 32'd10);
    check("jump slot REG21", dut.ID.REG[21], 32'd10);
    check("jump slot REG22", dut.ID.REG[22], 32'd10);
    check("jump skipped REG23", dut.ID.REG[23], SENT);

    // Reset mid-program
    begin_test();
    dut.ID.REG[30] <= 32'd7;
    dut.ID.REG[31] <= 32'd8;
    for (int r = 1; r <= 20; r++) dut.ID.REG[r] <= SENT;
    dut.MEM.DM[9] <= SENT;
    for (int i = 0; i < 20; i++)
      prog[i] = (i == 7) ? i_ins(6'h2B, 0, 30, 16'd9) : r_ins(6'h20, 30, 31, i + 1);
    go(10);
    rst = 1'b0;
    #1;
    check("midrst PC", dut.IF.PC, 32'd0);
    check("midrst FD_PC", dut.FD_PC, 32'd0);
    repeat (3) @(negedge clk);
    for (int r = 1; r <= 20; r++) begin
      if (r != 8) check($sformatf("midrst REG%0d", r), dut.ID.REG[r], (r <= 6) ? 32'd15 : SENT);
    end
    check("midrst DM9", dut.MEM.DM[9], SENT);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    for (int r = 1; r <= 20; r++) begin
      if (r != 8) check($sformatf("restart REG%0d", r), dut.ID.REG[r], 32'd15);
    end
    check("restart DM9", dut.MEM.DM[9], 32'd7);

    // Randomized programs, one instruction every third slot
    for (int it = 0; it < 3; it++) begin
      begin_test();
      m_reg[0] = '0;
      for (int r = 1; r < 32; r++) begin
        v = $urandom;
        m_reg[r] = v;
        dut.ID.REG[r] <= v;
      end
      for (int d = 0; d < 128; d++) begin
        v = $urandom;
        m_dm[d] = v;
        dut.MEM.DM[d] <= v;
      end
      for (int k = 0; k < 20; k++) begin
        kind = int'($urandom_range(0, 5));
        rs   = int'($urandom_range(0, 15));
        rt   = int'($urandom_range(0, 15));
        rd   = int'($urandom_range(0, 15));
        case (kind)
          0:       w = r_ins(6'h20, rs, rt, rd);
          1:       w = r_ins(6'h22, rs, rt, rd);
          2:       w = r_ins(6'h2A, rs, rt, rd);
          3:       w = i_ins(6'h23, rs, rt, 16'($urandom_range(0, 65535)));
          4:       w = i_ins(6'h2B, rs, rt, 16'($urandom_range(0, 65535)));
          default: w = ($urandom_range(0, 1) == 0) ? r_ins(6'h24, rs, rt, rd)
                                                   : i_ins(6'h0D, rs, rt, 16'($urandom_range(0, 65535)));
        endcase
        prog[3 * k] = w;
      end
      go(70);
      for (int k = 0; k < 20; k++) model_exec(prog[3 * k]);
      for (int r = 0; r < 32; r++) check($sformatf("rand%0d REG%0d", it, r), dut.ID.REG[r], m_reg[r]);
      for (int d = 0; d < 128; d++) check($sformatf("rand%0d DM%0d", it, d), dut.MEM.DM[d], m_dm[d]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
